mem_access_unit: RTL and testbench

Initiator-side load/store unit that drives the byte-addressed, big-endian, 4-byte-wide asynchronous-read data RAM on behalf of the MIPS MEM stage. It accepts one word, halfword or byte request at a time and produces the RAM address and write controls. Sub-word stores use a read-modify-write sequence because the RAM always writes all four bytes. Loads are returned lane-extracted and sign- or zero-extended.

---
 rtl/mem_access_pkg.sv | 34 +++
 rtl/mem_lane_align.sv | 47 ++++
 rtl/mem_access_unit.sv | 140 ++++++++++++++
 tb/tb_mem_access_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage load/store unit and its lane aligner.
package mem_access_pkg;

   // Access size field encodings
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   // Byte and half lane offsets within a big-endian word
   localparam logic [1:0] OFF_B0 = 2'b00;
   localparam logic [1:0] OFF_B1 = 2'b01;
   localparam logic [1:0] OFF_B2 = 2'b10;
   localparam logic [1:0] OFF_B3 = 2'b11;
   localparam logic [1:0] OFF_H0 = 2'b00;
   localparam logic [1:0] OFF_H2 = 2'b10;

   // Big-endian: byte offset k lives at bits [31-8k -: 8], so its LSB is 8*(3-k)
   function automatic logic [4:0] byte_lsb(input logic [1:0] off);
      return {~off, 3'b000};
   endfunction

   // Half offset 0 lives at [31:16], offset 2 at [15:0]
   function automatic logic [4:0] half_lsb(input logic [1:0] off);
      return {~off[1], 4'b0000};
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane aligner: load extract/extend and sub-word store merge
// for a big-endian 32-bit word. Shared with the uncached debug path.
module mem_lane_align
   import mem_access_pkg::*;
#(
   parameter int NB_DATA = 32
) (
   input  logic [NB_DATA-1:0] i_word,
   input  logic [1:0]         i_offset,
   input  logic [1:0]         i_size,
   input  logic               i_unsigned,
   input  logic [NB_DATA-1:0] i_wdata,
   output logic [NB_DATA-1:0] o_load,
   output logic [NB_DATA-1:0] o_merged
);

   logic [4:0]  w_byte_lsb;
   logic [4:0]  w_half_lsb;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte_lsb = byte_lsb(i_offset);
   assign w_half_lsb = half_lsb(i_offset);
   assign w_byte     = i_word[w_byte_lsb +: 8];
   assign w_half     = i_word[w_half_lsb +: 16];

   // Extract the addressed lane and sign- or zero-extend it
   always_comb begin
      o_load = i_word;
      case (i_size)
         SIZE_BYTE: o_load = {{(NB_DATA-8){~i_unsigned & w_byte[7]}}, w_byte};
         SIZE_HALF: o_load = {{(NB_DATA-16){~i_unsigned & w_half[15]}}, w_half};
         default:   o_load = i_word;
      endcase
   end

   // Overlay the right-justified store data onto the addressed lane
   always_comb begin
      o_merged = i_word;
      case (i_size)
         SIZE_BYTE: o_merged[w_byte_lsb +: 8]  = i_wdata[7:0];
         SIZE_HALF: o_merged[w_half_lsb +: 16] = i_wdata[15:0];
         default:   o_merged = i_wdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit driving a word-wide, asynchronous-read,
// big-endian data RAM. Sub-word stores are done as read-modify-write.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int NB_DATA     = 32,
   parameter int NB_ADDR     = 9,
   parameter int NB_REQ_ADDR = 32
) (
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   input  logic                   i_valid,
   input  logic                   i_we,
   input  logic [1:0]             i_size,
   input  logic                   i_unsigned,
   input  logic [NB_REQ_ADDR-1:0] i_addr,
   input  logic [NB_DATA-1:0]     i_wdata,
   output logic                   o_ready,
   output logic                   o_done,
   output logic                   o_err,
   output logic [NB_DATA-1:0]     o_rdata,
   output logic                   o_mem_we,
   output logic [NB_ADDR-1:0]     o_mem_addr,
   output logic [NB_DATA-1:0]     o_mem_wdata,
   input  logic [NB_DATA-1:0]     i_mem_rdata
);

   logic [1:0]         r_state;
   logic [1:0]         w_state_next;
   logic               r_we;
   logic               r_unsigned;
   logic               r_err;
   logic [1:0]         r_size;
   logic [1:0]         r_offset;
   logic [NB_DATA-1:0] r_wdata;
   logic [NB_DATA-1:0] r_rdata;
   logic [NB_DATA-1:0] r_mem_wdata;
   logic [NB_ADDR-1:0] r_mem_addr;

   logic               w_accept;
   logic               w_fault;
   logic [NB_DATA-1:0] w_load;
   logic [NB_DATA-1:0] w_merged;

   assign w_accept = i_valid && (r_state == ST_IDLE);

   // Classify the incoming request: bad size, misalignment or out-of-range address
   always_comb begin
      w_fault = |i_addr[NB_REQ_ADDR-1:NB_ADDR];
      case (i_size)
         SIZE_BYTE: ;
         SIZE_HALF: if (i_addr[0]) w_fault = 1'b1;
         SIZE_WORD: if (i_addr[1:0] != 2'b00) w_fault = 1'b1;
         default:   w_fault = 1'b1;
      endcase
   end

   // Next-state: faults go straight to RESP, sub-word stores read before writing
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_fault)
                  w_state_next = ST_RESP;
               else if (i_we && (i_size == SIZE_WORD))
                  w_state_next = ST_WRITE;
               else
                  w_state_next = ST_READ;
            end
         end
         ST_READ:  w_state_next = r_we ? ST_WRITE : ST_RESP;
         ST_WRITE: w_state_next = ST_RESP;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_next;
   end

   // Request latch, RAM address/write word, and load result capture
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_we        <= 1'b0;
         r_unsigned  <= 1'b0;
         r_err       <= 1'b0;
         r_size      <= SIZE_BYTE;
         r_offset    <= OFF_B0;
         r_wdata     <= '0;
         r_rdata     <= '0;
         r_mem_wdata <= '0;
         r_mem_addr  <= '0;
      end else begin
         if (w_accept) begin
            r_we       <= i_we;
            r_unsigned <= i_unsigned;
            r_err      <= w_fault;
            r_size     <= i_size;
            r_offset   <= i_addr[1:0];
            r_wdata    <= i_wdata;
            r_mem_addr <= {i_addr[NB_ADDR-1:2], 2'b00};
            if (i_we && (i_size == SIZE_WORD) && !w_fault)
               r_mem_wdata <= i_wdata;
         end
         if (r_state == ST_READ) begin
            if (r_we)
               r_mem_wdata <= w_merged;
            else
               r_rdata <= w_load;
         end
      end
   end

   mem_lane_align #(
      .NB_DATA (NB_DATA)
   ) u_lane_align (
      .i_word     (i_mem_rdata),
      .i_offset   (r_offset),
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .i_wdata    (r_wdata),
      .o_load     (w_load),
      .o_merged   (w_merged)
   );

   // Strobes decode straight from the state register so they never glitch
   assign o_ready     = (r_state == ST_IDLE);
   assign o_mem_we    = (r_state == ST_WRITE);
   assign o_done      = (r_state == ST_RESP);
   assign o_err       = (r_state == ST_RESP) && r_err;
   assign o_rdata     = r_rdata;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural big-endian RAM and
// a scoreboard of expected completions.
module tb_mem_access_unit;
   import mem_access_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        i_we = 1'b0;
   logic [1:0]  i_size = 2'b00;
   logic        i_unsigned = 1'b0;
   logic [31:0] i_addr = '0;
   logic [31:0] i_wdata = '0;
   logic        o_ready, o_done, o_err, mem_we;
   logic [31:0] o_rdata, mem_wdata, mem_rdata;
   logic [8:0]  mem_addr;

   logic        ram_clr = 1'b1;
   logic [31:0] ram [0:127];

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        err;
      logic        chk;
      logic [31:0] rd;
      int          dc;
      int          wc;
   } exp_t;
   exp_t sb[$];

   mem_access_unit dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_valid     (i_valid),
      .i_we        (i_we),
      .i_size      (i_size),
      .i_unsigned  (i_unsigned),
      .i_addr      (i_addr),
      .i_wdata     (i_wdata),
      .o_ready     (o_ready),
      .o_done      (o_done),
      .o_err       (o_err),
      .o_rdata     (o_rdata),
      .o_mem_we    (mem_we),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .i_mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // Word-wide RAM: asynchronous read, write on the rising edge
   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 128; i++) ram[i] <= '0;
      end else if (mem_we) begin
         ram[mem_addr[8:2]] <= mem_wdata;
      end
   end
   assign mem_rdata = ram[mem_addr[8:2]];

   initial begin
      #500000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkb(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ram_byte(input int a);
      logic [31:0] w;
      w = ram[a >> 2];
      return w[(3 - (a & 3)) * 8 +: 8];
   endfunction

   // Pop the oldest expectation and compare it with what the DUT produced
   task automatic pop_cmp(input string tag, input int dc, input int wc, input int wcnt);
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("FAIL %s_sb observed=empty expected=entry", tag);
         return;
      end
      e = sb.pop_front();
      check({tag, "_done_cyc"}, dc, e.dc);
      check({tag, "_we_cnt"}, wcnt, (e.wc < 0) ? 0 : 1);
      check({tag, "_we_cyc"}, wc, e.wc);
      checkb({tag, "_err"}, o_err, e.err);
      if (e.chk) check({tag, "_rdata"}, o_rdata, e.rd);
      $display("txn %s done_cyc=%0d we_cyc=%0d err=%0b rdata=%h", tag, dc, wc, o_err, o_rdata);
   endtask

   function automatic exp_t mk(input logic we, input logic ee, input logic [31:0] rd,
                               input int dc, input int wc);
      exp_t e;
      e.err = ee;
      e.chk = !we && !ee;
      e.rd  = rd;
      e.dc  = dc;
      e.wc  = wc;
      return e;
   endfunction

   task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
      i_valid    = 1'b1;
      i_we       = we;
      i_size     = sz;
      i_unsigned = uns;
      i_addr     = addr;
      i_wdata    = wd;
   endtask

   // From the accept edge, count cycles until o_done and record write strobes
   task automatic wait_done(input string tag, input logic [31:0] addr);
      int cyc, wcyc, wcnt;
      logic seen;
      @(posedge clk);
      cyc = 0; wcyc = -1; wcnt = 0; seen = 1'b0;
      while (!seen && cyc < 8) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            i_valid = 1'b0;
            check({tag, "_maddr"}, {23'd0, mem_addr}, {23'd0, addr[8:2], 2'b00});
         end
         if (mem_we) begin
            wcnt++;
            wcyc = cyc;
         end
         if (o_done) seen = 1'b1;
      end
      if (!seen) begin
         total++;
         bad++;
         $error("FAIL %s_timeout observed=no_done expected=done", tag);
         if (sb.size() != 0) void'(sb.pop_front());
      end else begin
         pop_cmp(tag, cyc, wcyc, wcnt);
      end
   endtask

   task automatic run_req(input string tag, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          input logic ee, input logic [31:0] erd, input int edc, input int ewc);
      @(negedge clk);
      checkb({tag, "_ready"}, o_ready, 1'b1);
      sb.push_back(mk(we, ee, erd, edc, ewc));
      drive(we, sz, uns, addr, wd);
      wait_done(tag, addr);
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkb("rst_ready", o_ready, 1'b1);
      checkb("rst_done", o_done, 1'b0);
      checkb("rst_err", o_err, 1'b0);
      checkb("rst_mem_we", mem_we, 1'b0);
      check("rst_rdata", o_rdata, 32'h0);
      check("rst_maddr", {23'd0, mem_addr}, 32'h0);
      check("rst_mwdata", mem_wdata, 32'h0);
      @(negedge clk);
      rst_n   = 1'b1;
      ram_clr = 1'b0;

      // Word store then word load
      run_req("sw_10", 1'b1, SIZE_WORD, 1'b0, 32'h010, 32'hDEADBEEF, 1'b0, 32'h0, 2, 1);
      run_req("lw_10", 1'b0, SIZE_WORD, 1'b0, 32'h010, 32'h0, 1'b0, 32'hDEADBEEF, 2, -1);
      check("ram_b10", {24'd0, ram_byte(32'h10)}, 32'hDE);
      check("ram_b11", {24'd0, ram_byte(32'h11)}, 32'hAD);
      check("ram_b12", {24'd0, ram_byte(32'h12)}, 32'hBE);
      check("ram_b13", {24'd0, ram_byte(32'h13)}, 32'hEF);

      // Sub-word read-modify-write stores
      run_req("sw_20", 1'b1, SIZE_WORD, 1'b0, 32'h020, 32'h11223344, 1'b0, 32'h0, 2, 1);
      run_req("sb_22", 1'b1, SIZE_BYTE, 1'b0, 32'h022, 32'h000000AA, 1'b0, 32'h0, 3, 2);
      check("ram_w20_sb", ram[8], 32'h1122AA44);
      run_req("sh_22", 1'b1, SIZE_HALF, 1'b0, 32'h022, 32'h00005566, 1'b0, 32'h0, 3, 2);
      check("ram_w20_sh2", ram[8], 32'h11225566);
      run_req("sh_20", 1'b1, SIZE_HALF, 1'b0, 32'h020, 32'h00007788, 1'b0, 32'h0, 3, 2);
      check("ram_w20_sh0", ram[8], 32'h77885566);
      run_req("sb_21", 1'b1, SIZE_BYTE, 1'b0, 32'h021, 32'hFFFFFF5A, 1'b0, 32'h0, 3, 2);
      check("ram_w20_sb1", ram[8], 32'h775A5566);

      // Load lane extraction and extension
      run_req("sw_30", 1'b1, SIZE_WORD, 1'b0, 32'h030, 32'h80FF7F01, 1'b0, 32'h0, 2, 1);
      run_req("lb_30", 1'b0, SIZE_BYTE, 1'b0, 32'h030, 32'h0, 1'b0, 32'hFFFFFF80, 2, -1);
      run_req("lbu_31", 1'b0, SIZE_BYTE, 1'b1, 32'h031, 32'h0, 1'b0, 32'h000000FF, 2, -1);
      run_req("lh_32", 1'b0, SIZE_HALF, 1'b0, 32'h032, 32'h0, 1'b0, 32'h00007F01, 2, -1);
      run_req("lh_30", 1'b0, SIZE_HALF, 1'b0, 32'h030, 32'h0, 1'b0, 32'hFFFF80FF, 2, -1);
      run_req("lhu_30", 1'b0, SIZE_HALF, 1'b1, 32'h030, 32'h0, 1'b0, 32'h000080FF, 2, -1);
      run_req("lb_33", 1'b0, SIZE_BYTE, 1'b0, 32'h033, 32'h0, 1'b0, 32'h00000001, 2, -1);
      run_req("lb_31", 1'b0, SIZE_BYTE, 1'b0, 32'h031, 32'h0, 1'b0, 32'hFFFFFFFF, 2, -1);

      // Faulting requests: no RAM write, result register untouched
      run_req("lw_005", 1'b0, SIZE_WORD, 1'b0, 32'h005, 32'h0, 1'b1, 32'h0, 1, -1);
      run_req("sh_201", 1'b1, SIZE_HALF, 1'b0, 32'h201, 32'h0000CDCD, 1'b1, 32'h0, 1, -1);
      run_req("sw_200", 1'b1, SIZE_WORD, 1'b0, 32'h200, 32'h12345678, 1'b1, 32'h0, 1, -1);
      run_req("s11_10", 1'b1, SIZE_RSVD, 1'b0, 32'h010, 32'h0BADF00D, 1'b1, 32'h0, 1, -1);
      run_req("lw_hi", 1'b0, SIZE_WORD, 1'b0, 32'h10000010, 32'h0, 1'b1, 32'h0, 1, -1);
      check("flt_rdata_hold", o_rdata, 32'hFFFFFFFF);
      check("flt_ram_w10", ram[4], 32'hDEADBEEF);
      check("flt_ram_w00", ram[0], 32'h0);
      check("flt_ram_w04", ram[1], 32'h0);

      // Asynchronous reset while the write strobe is up
      @(negedge clk);
      drive(1'b1, SIZE_WORD, 1'b0, 32'h040, 32'hCAFEF00D);
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      checkb("rstw_we_before", mem_we, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      checkb("rstw_we_drop", mem_we, 1'b0);
      checkb("rstw_ready", o_ready, 1'b1);
      checkb("rstw_done", o_done, 1'b0);
      check("rstw_maddr", {23'd0, mem_addr}, 32'h0);
      check("rstw_mwdata", mem_wdata, 32'h0);
      check("rstw_rdata", o_rdata, 32'h0);
      @(posedge clk);
      @(negedge clk);
      check("rstw_ram_w40", ram[16], 32'h0);
      rst_n = 1'b1;

      // Second request held during READ must wait for IDLE
      @(negedge clk);
      checkb("busy_ready_c0", o_ready, 1'b1);
      sb.push_back(mk(1'b0, 1'b0, 32'h80FF7F01, 2, -1));
      drive(1'b0, SIZE_WORD, 1'b0, 32'h030, 32'h0);
      @(posedge clk);
      @(negedge clk);
      checkb("busy_ready_c1", o_ready, 1'b0);
      sb.push_back(mk(1'b0, 1'b0, 32'h00000001, 2, -1));
      drive(1'b0, SIZE_BYTE, 1'b0, 32'h033, 32'h0);
      @(negedge clk);
      checkb("busy_done_c2", o_done, 1'b1);
      pop_cmp("busy_first", o_done ? 2 : 0, -1, 0);
      @(negedge clk);
      checkb("busy_ready_c3", o_ready, 1'b1);
      checkb("busy_done_c3", o_done, 1'b0);
      wait_done("busy_second", 32'h033);

      @(negedge clk);
      check("sb_drain", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
